// File: rtl/sr_bank_driver.sv
// rtl/sr_bank_driver.sv - drives a bank of SR flip-flops to a requested target word
//
// Purpose: accepts one target word per request. It pulses set/reset excitation
// only on the bits whose q feedback differs from the target. After a settle
// time it reads the bank back and reports done or err.
//
// Optional feature macro: SR_BANK_DRV_RETRY_EN
//   When this macro is defined, a readback mismatch re-pulses the bank.
//   Up to MAX_RETRY extra pulses are tried before err is reported.
//   When it is undefined, the first mismatch reports err.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  request present
//   req_ready  high in IDLE; a request is accepted on req_valid & req_ready
//   req_target target q word, sampled at the accepting edge
//   q_fb       q feedback from the SR bank
//   s_out      set excitation, one bit per cell
//   r_out      reset excitation, one bit per cell
//   busy       high whenever the state is not IDLE
//   done       one-cycle pulse: the readback matched the target
//   err        one-cycle pulse: the readback mismatched the target
//   err_mask   q_fb ^ target captured at the failing check; held until the next accept
module sr_bank_driver #(
  parameter int W          = 8,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 3,
  parameter int MAX_RETRY  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_target,
  input  logic [W-1:0] q_fb,
  output logic [W-1:0] s_out,
  output logic [W-1:0] r_out,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] err_mask
);

  localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, PULSE, SETTLE, CHECK, DONE, ERR
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   target_q;
  logic [W-1:0]   s_mask_q;
  logic [W-1:0]   r_mask_q;
  logic [W-1:0]   err_mask_q;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           match;
  logic           retry_ok;

  assign accept = req_valid && (state == IDLE);
  assign match  = (q_fb == target_q);

`ifdef SR_BANK_DRV_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt;
  assign retry_ok = (retry_cnt < RW'(MAX_RETRY));
`else
  assign retry_ok = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) begin
        // Nothing to change: skip straight to the done pulse.
        if ((req_target ^ q_fb) == '0) state_next = DONE;
        else                           state_next = PULSE;
      end
      PULSE:  if (cnt == CW'(PULSE_CYC - 1))  state_next = SETTLE;
      SETTLE: if (cnt == CW'(SETTLE_CYC - 1)) state_next = CHECK;
      CHECK: begin
        if (match)         state_next = DONE;
        else if (retry_ok) state_next = PULSE;
        else               state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: target, pulse masks, phase counter, error capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target_q   <= '0;
      s_mask_q   <= '0;
      r_mask_q   <= '0;
      err_mask_q <= '0;
      cnt        <= '0;
`ifdef SR_BANK_DRV_RETRY_EN
      retry_cnt  <= '0;
`endif
    end else begin
      // Counter restarts on every state entry, so it never wraps.
      if (state_next != state)
        cnt <= '0;
      else if (state == PULSE || state == SETTLE)
        cnt <= cnt + 1'b1;

      if (accept) begin
        target_q   <= req_target;
        // The masks are disjoint by construction, so the 11 code never reaches a cell.
        s_mask_q   <= req_target & ~q_fb;
        r_mask_q   <= ~req_target & q_fb;
        err_mask_q <= '0;
`ifdef SR_BANK_DRV_RETRY_EN
        retry_cnt  <= '0;
`endif
      end else if (state == CHECK && !match) begin
        if (state_next == ERR)
          err_mask_q <= q_fb ^ target_q;
`ifdef SR_BANK_DRV_RETRY_EN
        else begin
          s_mask_q  <= target_q & ~q_fb;
          r_mask_q  <= ~target_q & q_fb;
          retry_cnt <= retry_cnt + 1'b1;
        end
`endif
      end
    end
  end

  // Outputs: decoded only from registers. s_out and r_out depend on the state,
  // so they drop as soon as the asynchronous reset forces IDLE.
  always_comb begin
    s_out     = '0;
    r_out     = '0;
    done      = 1'b0;
    err       = 1'b0;
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    err_mask  = err_mask_q;
    case (state)
      PULSE: begin
        s_out = s_mask_q;
        r_out = r_mask_q;
      end
      DONE:    done = 1'b1;
      ERR:     err  = 1'b1;
      default: ;
    endcase
  end

endmodule
